ean13_result_arbiter: RTL and testbench

//  Sequences the EAN-13 line scanner. Gates its per-line scan window, captures each decoded
//  52-bit code, verifies the check digit serially, and votes across consecutive lines.

---
 rtl/ean13_result_arbiter_pkg.sv | 30 +++
 rtl/ean13_result_arbiter_checksum_seq.sv | 47 ++++
 rtl/ean13_result_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ean13_result_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ean13_result_arbiter_pkg.sv
// Shared types and helpers for the EAN-13 result arbiter: one-hot FSM states,
// code geometry, checksum weighting and mod-10 reduction.
package ean13_result_arbiter_pkg;

  localparam int EAN_DIGITS = 13;
  localparam int CODE_W     = 4 * EAN_DIGITS;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_CHECK   = 4'b0010,
    ST_VOTE    = 4'b0100,
    ST_PUBLISH = 4'b1000
  } arbState_t;

  // Leading digit (index 0) has weight 1, then 3,1,3,... ending on weight 1.
  function automatic logic [1:0] digitWeight(input logic [3:0] idx);
    return idx[0] ? 2'd3 : 2'd1;
  endfunction

  // Compare/subtract chain; exact for any sum below 60.
  function automatic logic [3:0] mod10(input logic [5:0] sum);
    logic [5:0] s;
    s = sum;
    if (s >= 6'd40) s = s - 6'd40;
    if (s >= 6'd20) s = s - 6'd20;
    if (s >= 6'd10) s = s - 6'd10;
    return s[3:0];
  endfunction

endpackage

// File: rtl/ean13_result_arbiter_checksum_seq.sv
// Serial EAN-13 check-digit datapath: one digit per cycle after start, leading digit first.
module ean13_checksum_seq
  import ean13_result_arbiter_pkg::*;
(
  input  logic       iClk,
  input  logic       iRstN,
  input  logic       start,
  input  logic [3:0] digit,
  output logic [3:0] digitIdx,
  output logic       done,
  output logic       ok
);

  logic [3:0] acc;
  logic       bad;
  logic       busy;
  logic [5:0] sum;

  always_comb begin
    sum = 6'(acc) + 6'(digitWeight(digitIdx)) * 6'(digit);
  end

  // done flags the cycle consuming the last digit; ok is meaningful the cycle after.
  assign done = busy && (digitIdx == 4'(EAN_DIGITS - 1));
  assign ok   = (acc == 4'd0) && !bad;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      acc      <= '0;
      bad      <= 1'b0;
      busy     <= 1'b0;
      digitIdx <= '0;
    end else if (start) begin
      acc      <= '0;
      bad      <= 1'b0;
      busy     <= 1'b1;
      digitIdx <= '0;
    end else if (busy) begin
      acc      <= mod10(sum);
      bad      <= bad | (digit > 4'd9);
      digitIdx <= digitIdx + 4'd1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ean13_result_arbiter.sv
// EAN-13 scan sequencer: line window, capture, serial check digit, vote and publish.
// Define EAN_ARB_STATS_EN to add the oStatOk/oStatErr/oStatDrop saturating counters.
module ean13_result_arbiter
  import ean13_result_arbiter_pkg::*;
#(
  parameter int LINE_FIRST  = 4,
  parameter int LINE_LAST   = 11,
  parameter int VOTE_COUNT  = 3,
  parameter int HOLD_FRAMES = 2
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iFrameStart,
  input  logic              iLineStart,
  input  logic              iNewData,
  input  logic [CODE_W-1:0] iDataCode,
  output logic              oScanEnable,
  output logic [CODE_W-1:0] oCode,
  output logic              oValid,
  input  logic              iReady,
  output logic              oChkErr,
  output logic              oDrop
`ifdef EAN_ARB_STATS_EN
  ,
  output logic [15:0]       oStatOk,
  output logic [15:0]       oStatErr,
  output logic [15:0]       oStatDrop
`endif
);

  arbState_t         state;
  logic              newPrev;
  logic              newEdge;
  logic [4:0]        lineCnt;
  logic [CODE_W-1:0] capReg;
  logic [CODE_W-1:0] cand;
  logic [CODE_W-1:0] lastPub;
  logic [3:0]        matchCnt;
  logic [3:0]        missCnt;
  logic [3:0]        voteCnt;
  logic              pubLock;
  logic              seenThisFrame;
  logic              chkStart;
  logic              chkDone;
  logic              chkOk;
  logic [3:0]        chkIdx;
  logic [3:0]        chkDigit;

  assign newEdge  = iNewData & ~newPrev;
  assign chkStart = (state == ST_IDLE) && newEdge;

  // NOTE: always_comb outputs get a default first so no path can infer a latch.
  always_comb begin
    chkDigit = '0;
    for (int i = 0; i < EAN_DIGITS; i++) begin
      if (chkIdx == 4'(i)) chkDigit = capReg[CODE_W-1-4*i -: 4];
    end
    voteCnt = 4'd1;
    if (capReg == cand) voteCnt = (matchCnt == 4'hF) ? matchCnt : matchCnt + 4'd1;
  end

  ean13_checksum_seq uChecksum (
    .iClk    (iClk),
    .iRstN   (iRstN),
    .start   (chkStart),
    .digit   (chkDigit),
    .digitIdx(chkIdx),
    .done    (chkDone),
    .ok      (chkOk)
  );

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state         <= ST_IDLE;
      newPrev       <= 1'b0;
      lineCnt       <= '0;
      oScanEnable   <= 1'b0;
      capReg        <= '0;
      cand          <= '0;
      lastPub       <= '0;
      matchCnt      <= '0;
      missCnt       <= '0;
      pubLock       <= 1'b0;
      seenThisFrame <= 1'b0;
      oCode         <= '0;
      oValid        <= 1'b0;
      oChkErr       <= 1'b0;
      oDrop         <= 1'b0;
    end else begin
      newPrev     <= iNewData;
      oChkErr     <= 1'b0;
      oDrop       <= newEdge && (state != ST_IDLE);

      if (iFrameStart)                         lineCnt <= '0;
      else if (iLineStart && lineCnt != 5'd31) lineCnt <= lineCnt + 5'd1;
      oScanEnable <= (lineCnt >= 5'(LINE_FIRST)) && (lineCnt <= 5'(LINE_LAST));

      // Hold-off: a published code stays locked until HOLD_FRAMES frames pass without it.
      if (iFrameStart) begin
        if (pubLock && !seenThisFrame) begin
          if (5'(missCnt) + 5'd1 >= 5'(HOLD_FRAMES)) begin
            pubLock <= 1'b0;
            missCnt <= '0;
          end else begin
            missCnt <= missCnt + 4'd1;
          end
        end else begin
          missCnt <= '0;
        end
        seenThisFrame <= 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          if (newEdge) begin
            capReg <= iDataCode;
            state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (chkDone) state <= ST_VOTE;
        end
        ST_VOTE: begin
          state <= ST_IDLE;
          if (!chkOk) begin
            oChkErr <= 1'b1;
          end else begin
            cand     <= capReg;
            matchCnt <= voteCnt;
            if (pubLock && capReg == lastPub) begin
              seenThisFrame <= 1'b1;
            end else if (voteCnt == 4'(VOTE_COUNT)) begin
              oCode  <= capReg;
              oValid <= 1'b1;
              state  <= ST_PUBLISH;
            end
          end
        end
        ST_PUBLISH: begin
          if (iReady) begin
            oValid        <= 1'b0;
            lastPub       <= oCode;
            pubLock       <= 1'b1;
            matchCnt      <= '0;
            seenThisFrame <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef EAN_ARB_STATS_EN
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oStatOk   <= '0;
      oStatErr  <= '0;
      oStatDrop <= '0;
    end else begin
      if (oValid && iReady && oStatOk != 16'hFFFF) oStatOk   <= oStatOk + 16'd1;
      if (oChkErr && oStatErr != 16'hFFFF)         oStatErr  <= oStatErr + 16'd1;
      if (oDrop && oStatDrop != 16'hFFFF)          oStatDrop <= oStatDrop + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ean13_result_arbiter.sv
// Self-checking bench for ean13_result_arbiter against a behavioural vote/checksum model.
module tb_ean13_result_arbiter;

  localparam int LINE_FIRST  = 4;
  localparam int LINE_LAST   = 11;
  localparam int VOTE_COUNT  = 3;
  localparam int HOLD_FRAMES = 2;

  localparam logic [51:0] CODE_A   = 52'h4006381333931;
  localparam logic [51:0] CODE_BAD = 52'h4006381333932;
  localparam logic [51:0] CODE_B   = 52'h5901234123457;

  typedef enum {V_NONE, V_ERR, V_PUB} verdict_t;

  logic        iClk = 1'b0;
  logic        iRstN;
  logic        iFrameStart;
  logic        iLineStart;
  logic        iNewData;
  logic [51:0] iDataCode;
  logic        iReady;
  logic        oScanEnable;
  logic [51:0] oCode;
  logic        oValid;
  logic        oChkErr;
  logic        oDrop;
`ifdef EAN_ARB_STATS_EN
  logic [15:0] oStatOk, oStatErr, oStatDrop;
`endif

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state
  logic [51:0] mCand, mLastPub;
  int          mMatch, mMiss;
  bit          mLock, mSeen;

  ean13_result_arbiter #(
    .LINE_FIRST (LINE_FIRST),
    .LINE_LAST  (LINE_LAST),
    .VOTE_COUNT (VOTE_COUNT),
    .HOLD_FRAMES(HOLD_FRAMES)
  ) dut (
    .iClk       (iClk),
    .iRstN      (iRstN),
    .iFrameStart(iFrameStart),
    .iLineStart (iLineStart),
    .iNewData   (iNewData),
    .iDataCode  (iDataCode),
    .oScanEnable(oScanEnable),
    .oCode      (oCode),
    .oValid     (oValid),
    .iReady     (iReady),
    .oChkErr    (oChkErr),
    .oDrop      (oDrop)
`ifdef EAN_ARB_STATS_EN
    ,
    .oStatOk    (oStatOk),
    .oStatErr   (oStatErr),
    .oStatDrop  (oStatDrop)
`endif
  );

  always #5 iClk = ~iClk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  function automatic bit checksumOk(input logic [51:0] code);
    int sum;
    int d;
    sum = 0;
    for (int i = 0; i < 13; i++) begin
      d = int'(code[51-4*i -: 4]);
      if (d > 9) return 1'b0;
      sum += ((i % 2) ? 3 : 1) * d;
    end
    return (sum % 10) == 0;
  endfunction

  function automatic logic [51:0] makeValid();
    logic [51:0] c;
    int sum;
    int d;
    c = '0;
    sum = 0;
    for (int i = 0; i < 12; i++) begin
      d = int'($urandom_range(0, 9));
      c[51-4*i -: 4] = 4'(d);
      sum += ((i % 2) ? 3 : 1) * d;
    end
    c[3:0] = 4'((10 - sum % 10) % 10);
    return c;
  endfunction

  task automatic modelReset();
    mCand = '0; mLastPub = '0; mMatch = 0; mMiss = 0; mLock = 0; mSeen = 0;
  endtask

  task automatic modelEdge(input logic [51:0] code, output verdict_t v);
    v = V_NONE;
    if (!checksumOk(code)) begin
      v = V_ERR;
    end else begin
      mMatch = (code == mCand) ? ((mMatch < 15) ? mMatch + 1 : 15) : 1;
      mCand  = code;
      if (mLock && code == mLastPub) mSeen = 1;
      else if (mMatch == VOTE_COUNT) v = V_PUB;
    end
  endtask

  task automatic modelAccept(input logic [51:0] code);
    mLastPub = code; mLock = 1; mMatch = 0; mSeen = 1;
  endtask

  task automatic modelFrame();
    if (mLock && !mSeen) begin
      mMiss++;
      if (mMiss >= HOLD_FRAMES) begin
        mLock = 0;
        mMiss = 0;
      end
    end else begin
      mMiss = 0;
    end
    mSeen = 0;
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic pulseLine();
    iLineStart = 1'b1;
    tick();
    iLineStart = 1'b0;
  endtask

  task automatic pulseFrame();
    iFrameStart = 1'b1;
    tick();
    iFrameStart = 1'b0;
    modelFrame();
  endtask

  // Raise iNewData for one clock, then run until 'cycles' clock edges have passed in total.
  task automatic edgeAndRun(input logic [51:0] code, input int cycles);
    iDataCode = code;
    iNewData  = 1'b1;
    tick();
    iNewData  = 1'b0;
    repeat (cycles - 1) tick();
  endtask

  task automatic doReset();
    iRstN = 1'b0; iNewData = 1'b0; iFrameStart = 1'b0; iLineStart = 1'b0;
    iReady = 1'b1; iDataCode = '0;
    tick();
    tick();
    iRstN = 1'b1;
    tick();
    modelReset();
  endtask

  task automatic test_reset();
    iRstN = 1'b0; iNewData = 1'b1; iFrameStart = 1'b1; iLineStart = 1'b1;
    iDataCode = CODE_A; iReady = 1'b1;
    repeat (3) tick();
    nChecks++; if (oValid !== 1'b0) begin nFails++; $display("FAIL reset_valid: got %b expected 0", oValid); end
    nChecks++; if (oCode !== 52'h0) begin nFails++; $display("FAIL reset_code: got %h expected 0", oCode); end
    nChecks++; if (oChkErr !== 1'b0) begin nFails++; $display("FAIL reset_chkerr: got %b expected 0", oChkErr); end
    nChecks++; if (oDrop !== 1'b0) begin nFails++; $display("FAIL reset_drop: got %b expected 0", oDrop); end
    nChecks++; if (oScanEnable !== 1'b0) begin nFails++; $display("FAIL reset_scan: got %b expected 0", oScanEnable); end
  endtask

  task automatic test_vote_publish();
    verdict_t v;
    int beats;
    beats = 0;
    doReset();
    pulseFrame();
    for (int k = 0; k < 5; k++) begin
      pulseLine();
      tick();
      modelEdge(CODE_A, v);
      edgeAndRun(CODE_A, 14);
      nChecks++; if (oValid !== 1'b0) begin nFails++; $display("FAIL vote_early_valid line %0d: got %b expected 0", k, oValid); end
      tick();
      if (oValid === 1'b1) beats++;
      nChecks++; if (oValid !== (v == V_PUB)) begin nFails++; $display("FAIL vote_valid line %0d: got %b expected %b", k, oValid, v == V_PUB); end
      nChecks++; if (oChkErr !== 1'b0) begin nFails++; $display("FAIL vote_chkerr line %0d: got %b expected 0", k, oChkErr); end
      if (v == V_PUB) begin
        nChecks++; if (oCode !== CODE_A) begin nFails++; $display("FAIL vote_code: got %h expected %h", oCode, CODE_A); end
        tick();
        nChecks++; if (oValid !== 1'b0) begin nFails++; $display("FAIL vote_accept: got %b expected 0", oValid); end
        modelAccept(CODE_A);
      end
      tick();
    end
    nChecks++; if (beats !== 1) begin nFails++; $display("FAIL vote_beats: got %0d expected 1", beats); end
  endtask

  task automatic test_bad_check();
    verdict_t v;
    logic [51:0] seq [4];
    seq = '{CODE_A, CODE_A, CODE_BAD, CODE_A};
    doReset();
    pulseFrame();
    for (int k = 0; k < 4; k++) begin
      modelEdge(seq[k], v);
      edgeAndRun(seq[k], 15);
      nChecks++; if (oChkErr !== (v == V_ERR)) begin nFails++; $display("FAIL bad_chkerr step %0d: got %b expected %b", k, oChkErr, v == V_ERR); end
      nChecks++; if (oValid !== (v == V_PUB)) begin nFails++; $display("FAIL bad_valid step %0d: got %b expected %b", k, oValid, v == V_PUB); end
      if (v == V_PUB) begin
        nChecks++; if (oCode !== CODE_A) begin nFails++; $display("FAIL bad_code: got %h expected %h", oCode, CODE_A); end
        modelAccept(CODE_A);
      end
      tick();
      nChecks++; if (oChkErr !== 1'b0) begin nFails++; $display("FAIL bad_pulse_width step %0d: got %b expected 0", k, oChkErr); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    verdict_t v;
    doReset();
    iReady = 1'b0;
    pulseFrame();
    for (int k = 0; k < 3; k++) begin
      modelEdge(CODE_A, v);
      edgeAndRun(CODE_A, 15);
      nChecks++; if (oValid !== (v == V_PUB)) begin nFails++; $display("FAIL bp_valid edge %0d: got %b expected %b", k, oValid, v == V_PUB); end
      if (k < 2) tick();
    end
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        iDataCode = CODE_B;
        iNewData  = 1'b1;
      end else begin
        iNewData  = 1'b0;
      end
      tick();
      nChecks++; if (oValid !== 1'b1 || oCode !== CODE_A) begin nFails++; $display("FAIL bp_hold cycle %0d: got %b/%h expected 1/%h", i, oValid, oCode, CODE_A); end
      nChecks++; if (oDrop !== (i == 10)) begin nFails++; $display("FAIL bp_drop cycle %0d: got %b expected %b", i, oDrop, i == 10); end
    end
    iReady = 1'b1;
    tick();
    nChecks++; if (oValid !== 1'b0) begin nFails++; $display("FAIL bp_accept: got %b expected 0", oValid); end
    modelAccept(CODE_A);
    tick();
    // Publish a different code under backpressure, then reset while it waits.
    iReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      modelEdge(CODE_B, v);
      edgeAndRun(CODE_B, 15);
      nChecks++; if (oValid !== (v == V_PUB)) begin nFails++; $display("FAIL bp2_valid edge %0d: got %b expected %b", k, oValid, v == V_PUB); end
      if (k < 2) tick();
    end
    #2;
    iRstN = 1'b0;
    #1;
    nChecks++; if (oValid !== 1'b0 || oCode !== 52'h0) begin nFails++; $display("FAIL bp_reset_drop: got %b/%h expected 0/0", oValid, oCode); end
    doReset();
  endtask

  task automatic test_hold();
    verdict_t v;
    int beats;
    logic [51:0] steps [14];
    // An all-zero entry marks a frame start.
    steps = '{52'h0, CODE_A, CODE_A, CODE_A, 52'h0, CODE_A, 52'h0, CODE_B,
              52'h0, CODE_B, 52'h0, CODE_A, CODE_A, CODE_A};
    beats = 0;
    doReset();
    for (int k = 0; k < 14; k++) begin
      if (steps[k] == 52'h0) begin
        pulseFrame();
        tick();
      end else begin
        modelEdge(steps[k], v);
        edgeAndRun(steps[k], 15);
        if (oValid === 1'b1) beats++;
        nChecks++; if (oValid !== (v == V_PUB)) begin nFails++; $display("FAIL hold_valid step %0d: got %b expected %b", k, oValid, v == V_PUB); end
        if (v == V_PUB) begin
          nChecks++; if (oCode !== steps[k]) begin nFails++; $display("FAIL hold_code step %0d: got %h expected %h", k, oCode, steps[k]); end
          tick();
          modelAccept(steps[k]);
        end
        tick();
      end
    end
    nChecks++; if (beats !== 2) begin nFails++; $display("FAIL hold_beats: got %0d expected 2", beats); end
  endtask

  task automatic test_back_to_back();
    verdict_t v;
    doReset();
    pulseFrame();
    modelEdge(CODE_A, v);
    iDataCode = CODE_A;
    iNewData  = 1'b1;
    tick();
    iNewData  = 1'b0;
    repeat (4) tick();
    iDataCode = CODE_BAD;
    iNewData  = 1'b1;
    tick();
    nChecks++; if (oDrop !== 1'b1) begin nFails++; $display("FAIL b2b_drop: got %b expected 1", oDrop); end
    iNewData  = 1'b0;
    tick();
    nChecks++; if (oDrop !== 1'b0) begin nFails++; $display("FAIL b2b_drop_width: got %b expected 0", oDrop); end
    repeat (8) tick();
    nChecks++; if (oChkErr !== (v == V_ERR) || oValid !== (v == V_PUB)) begin nFails++; $display("FAIL b2b_first: got err=%b valid=%b expected err=%b valid=%b", oChkErr, oValid, v == V_ERR, v == V_PUB); end
    tick();
    for (int k = 0; k < 2; k++) begin
      modelEdge(CODE_A, v);
      edgeAndRun(CODE_A, 15);
      nChecks++; if (oValid !== (v == V_PUB)) begin nFails++; $display("FAIL b2b_vote edge %0d: got %b expected %b", k, oValid, v == V_PUB); end
      if (v == V_PUB) begin
        nChecks++; if (oCode !== CODE_A) begin nFails++; $display("FAIL b2b_code: got %h expected %h", oCode, CODE_A); end
        tick();
        modelAccept(CODE_A);
      end
      tick();
    end
  endtask

  task automatic test_line_window();
    int lineNo;
    doReset();
    pulseFrame();
    for (int k = 1; k <= 12; k++) begin
      pulseLine();
      tick();
      nChecks++; if (oScanEnable !== (k >= LINE_FIRST && k <= LINE_LAST)) begin nFails++; $display("FAIL window line %0d: got %b expected %b", k, oScanEnable, k >= LINE_FIRST && k <= LINE_LAST); end
    end
    iFrameStart = 1'b1;
    iLineStart  = 1'b1;
    tick();
    iFrameStart = 1'b0;
    iLineStart  = 1'b0;
    modelFrame();
    tick();
    nChecks++; if (oScanEnable !== 1'b0) begin nFails++; $display("FAIL window_frame_line: got %b expected 0", oScanEnable); end
    for (int k = 1; k <= 40; k++) begin
      pulseLine();
      tick();
      lineNo = (k > 31) ? 31 : k;
      nChecks++; if (oScanEnable !== (lineNo >= LINE_FIRST && lineNo <= LINE_LAST)) begin nFails++; $display("FAIL window_sat line %0d: got %b expected %b", k, oScanEnable, lineNo >= LINE_FIRST && lineNo <= LINE_LAST); end
    end
  endtask

  task automatic test_random();
    verdict_t v;
    logic [51:0] code;
    logic [51:0] rnd;
    int r;
    doReset();
    pulseFrame();
    rnd = makeValid();
    for (int it = 0; it < 60; it++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        pulseFrame();
      end else begin
        code = (r < 5) ? CODE_A : (r < 7) ? CODE_B : (r < 8) ? CODE_BAD : rnd;
        modelEdge(code, v);
        edgeAndRun(code, 15);
        nChecks++; if (oValid !== (v == V_PUB) || oChkErr !== (v == V_ERR)) begin nFails++; $display("FAIL rand it %0d code %h: got valid=%b err=%b expected valid=%b err=%b", it, code, oValid, oChkErr, v == V_PUB, v == V_ERR); end
        if (v == V_PUB) begin
          nChecks++; if (oCode !== code) begin nFails++; $display("FAIL rand_code it %0d: got %h expected %h", it, oCode, code); end
          tick();
          nChecks++; if (oValid !== 1'b0) begin nFails++; $display("FAIL rand_accept it %0d: got %b expected 0", it, oValid); end
          modelAccept(code);
        end
        tick();
      end
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  initial begin
    iRstN = 1'b0; iNewData = 1'b0; iFrameStart = 1'b0; iLineStart = 1'b0;
    iReady = 1'b1; iDataCode = '0;
    modelReset();
    test_reset();
    test_vote_publish();
    test_bad_check();
    test_backpressure();
    test_hold();
    test_back_to_back();
    test_line_window();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
